// File: rtl/perf_event_stage.sv
// ---------------------------------------------------------------------------
// perf_event_stage
//
// Event pre-processing stage that sits directly in front of the performance
// counter file. Every raw microarchitectural event is registered once, so
// inc_o follows an event by exactly one cycle. Commit-port events are counted
// across all commit ports, which keeps multi-commit cycles from being lost.
// While the counter file is writing a counter (hold_i[e]), that event's
// increments are collected in a small pending accumulator and released in
// one lump when the hold drops.
//
// Ports
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   clr_i              synchronous clear of raw, pending and lost state
//   debug_mode_i       suppresses event capture while the core is in debug
//   inhibit_i          per-event capture inhibit
//   hold_i             per-event defer request from the counter file
//   commit_instr_i     committing instructions, NrCommitPorts packed slots;
//                      slot layout (LSB first):
//                        [4:0]                         rd
//                        [9:5]                         rs1
//                        [10 +: OpWidth]               op
//                        [10+OpWidth +: FuWidth]       fu
//   commit_ack_i       commit acknowledge per port
//   l1_icache_miss_i   miss pulses
//   l1_dcache_miss_i
//   itlb_miss_i
//   dtlb_miss_i
//   sb_full_i          stall-cycle indicators
//   if_empty_i
//   ex_i               exception valid
//   eret_i             exception return
//   resolved_branch_i  {valid, is_mispredict}
//   inc_o              per-event increment, slot e at [e*AccWidth +: AccWidth]
//   lost_o             sticky: increments dropped by accumulator saturation
//
// Event index map
//   0 icache miss   1 dcache miss   2 itlb miss   3 dtlb miss
//   4 load          5 store         6 branch/jump 7 call      8 return
//   9 exception     10 eret         11 mispredict 12 sb full  13 if empty
// ---------------------------------------------------------------------------
module perf_event_stage #(
    parameter int NrEvents      = 14,
    parameter int AccWidth      = 4,
    parameter int NrCommitPorts = 2,
    parameter int FuWidth       = 4,
    parameter int OpWidth       = 8,
    parameter logic [FuWidth-1:0] FuLoad     = 4'd1,
    parameter logic [FuWidth-1:0] FuStore    = 4'd2,
    parameter logic [FuWidth-1:0] FuCtrlFlow = 4'd4,
    parameter logic [OpWidth-1:0] OpAdd      = 8'd0,
    parameter logic [OpWidth-1:0] OpJalr     = 8'd14
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            clr_i,
    input  logic                                            debug_mode_i,
    input  logic [NrEvents-1:0]                             inhibit_i,
    input  logic [NrEvents-1:0]                             hold_i,
    input  logic [NrCommitPorts*(FuWidth+OpWidth+10)-1:0]   commit_instr_i,
    input  logic [NrCommitPorts-1:0]                        commit_ack_i,
    input  logic                                            l1_icache_miss_i,
    input  logic                                            l1_dcache_miss_i,
    input  logic                                            itlb_miss_i,
    input  logic                                            dtlb_miss_i,
    input  logic                                            sb_full_i,
    input  logic                                            if_empty_i,
    input  logic                                            ex_i,
    input  logic                                            eret_i,
    input  logic [1:0]                                      resolved_branch_i,
    output logic [NrEvents*AccWidth-1:0]                    inc_o,
    output logic [NrEvents-1:0]                             lost_o
);

    localparam int CommitWidth = FuWidth + OpWidth + 10;
    localparam int RdLsb       = 0;
    localparam int Rs1Lsb      = 5;
    localparam int OpLsb       = 10;
    localparam int FuLsb       = 10 + OpWidth;

    localparam logic [AccWidth-1:0] AccOne = AccWidth'(1);
    localparam logic [AccWidth-1:0] AccMax = {AccWidth{1'b1}};

    localparam int EvIcache   = 0;
    localparam int EvDcache   = 1;
    localparam int EvItlb     = 2;
    localparam int EvDtlb     = 3;
    localparam int EvLoad     = 4;
    localparam int EvStore    = 5;
    localparam int EvBranch   = 6;
    localparam int EvCall     = 7;
    localparam int EvReturn   = 8;
    localparam int EvExcept   = 9;
    localparam int EvEret     = 10;
    localparam int EvMispred  = 11;
    localparam int EvSbFull   = 12;
    localparam int EvIfEmpty  = 13;

    // Widen a single-bit event to an increment amount.
    function automatic logic [AccWidth-1:0] ext(input logic b);
        return {{(AccWidth-1){1'b0}}, b};
    endfunction

    // -----------------------------------------------------------------------
    // Per-port decode of commit events
    // -----------------------------------------------------------------------
    logic [NrCommitPorts-1:0] is_load;
    logic [NrCommitPorts-1:0] is_store;
    logic [NrCommitPorts-1:0] is_branch;
    logic [NrCommitPorts-1:0] is_call;
    logic [NrCommitPorts-1:0] is_return;

    for (genvar g = 0; g < NrCommitPorts; g++) begin : g_port
        logic [CommitWidth-1:0] instr;
        logic [FuWidth-1:0]     fu;
        logic [OpWidth-1:0]     op;
        logic [4:0]             rs1;
        logic [4:0]             rd;
        logic                   rd_link;
        logic                   rs1_link;

        assign instr = commit_instr_i[g*CommitWidth +: CommitWidth];
        assign fu    = instr[FuLsb +: FuWidth];
        assign op    = instr[OpLsb +: OpWidth];
        assign rs1   = instr[Rs1Lsb +: 5];
        assign rd    = instr[RdLsb +: 5];

        // x1 (ra) and x5 (t0) are the link registers.
        assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
        assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

        assign is_load[g]   = (fu == FuLoad);
        assign is_store[g]  = (fu == FuStore);
        assign is_branch[g] = (fu == FuCtrlFlow);
        // A JAL is encoded as a control-flow op with ADD computing the link.
        assign is_call[g]   = (fu == FuCtrlFlow) && (op == OpAdd) && rd_link;
        assign is_return[g] = (op == OpJalr) && rs1_link && (rd == 5'd0);
    end

    // -----------------------------------------------------------------------
    // Commit event counts over all acknowledged ports
    // -----------------------------------------------------------------------
    logic [AccWidth-1:0] n_load;
    logic [AccWidth-1:0] n_store;
    logic [AccWidth-1:0] n_branch;
    logic [AccWidth-1:0] n_call;
    logic [AccWidth-1:0] n_return;

    always_comb begin
        n_load   = '0;
        n_store  = '0;
        n_branch = '0;
        n_call   = '0;
        n_return = '0;
        for (int i = 0; i < NrCommitPorts; i++) begin
            if (commit_ack_i[i]) begin
                if (is_load[i])   n_load   = n_load   + AccOne;
                if (is_store[i])  n_store  = n_store  + AccOne;
                if (is_branch[i]) n_branch = n_branch + AccOne;
                if (is_call[i])   n_call   = n_call   + AccOne;
                if (is_return[i]) n_return = n_return + AccOne;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 0: raw event amounts, gated by debug mode and inhibit
    // -----------------------------------------------------------------------
    logic [NrEvents-1:0][AccWidth-1:0] raw_d;

    always_comb begin
        raw_d            = '0;
        raw_d[EvIcache]  = ext(l1_icache_miss_i);
        raw_d[EvDcache]  = ext(l1_dcache_miss_i);
        raw_d[EvItlb]    = ext(itlb_miss_i);
        raw_d[EvDtlb]    = ext(dtlb_miss_i);
        raw_d[EvLoad]    = n_load;
        raw_d[EvStore]   = n_store;
        raw_d[EvBranch]  = n_branch;
        raw_d[EvCall]    = n_call;
        raw_d[EvReturn]  = n_return;
        raw_d[EvExcept]  = ext(ex_i);
        raw_d[EvEret]    = ext(eret_i);
        raw_d[EvMispred] = ext(resolved_branch_i[1] && resolved_branch_i[0]);
        raw_d[EvSbFull]  = ext(sb_full_i);
        raw_d[EvIfEmpty] = ext(if_empty_i);
        for (int e = 0; e < NrEvents; e++) begin
            if (debug_mode_i || inhibit_i[e]) begin
                raw_d[e] = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: combine registered events with pending amounts
    // -----------------------------------------------------------------------
    logic [NrEvents-1:0][AccWidth-1:0] raw_q;
    logic [NrEvents-1:0][AccWidth-1:0] pend_q;
    logic [NrEvents-1:0][AccWidth-1:0] pend_d;
    logic [NrEvents-1:0][AccWidth-1:0] inc;
    logic [NrEvents-1:0][AccWidth:0]   sum;
    logic [NrEvents-1:0][AccWidth-1:0] sat;
    logic [NrEvents-1:0]               clip;
    logic [NrEvents-1:0]               lost_q;

    // The sum is one bit wider than the accumulator so that a clip can be
    // detected; the same saturated value is either emitted or parked,
    // which lets a hold release and a new event land in the same cycle.
    always_comb begin
        sum    = '0;
        sat    = '0;
        clip   = '0;
        inc    = '0;
        pend_d = '0;
        for (int e = 0; e < NrEvents; e++) begin
            sum[e]  = {1'b0, raw_q[e]} + {1'b0, pend_q[e]};
            clip[e] = sum[e] > {1'b0, AccMax};
            sat[e]  = clip[e] ? AccMax : sum[e][AccWidth-1:0];
            if (hold_i[e]) begin
                pend_d[e] = sat[e];
            end else begin
                inc[e] = sat[e];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raw_q  <= '0;
            pend_q <= '0;
            lost_q <= '0;
        end else if (clr_i) begin
            // Events presented during the clear cycle are discarded.
            raw_q  <= '0;
            pend_q <= '0;
            lost_q <= '0;
        end else begin
            raw_q  <= raw_d;
            pend_q <= pend_d;
            lost_q <= lost_q | clip;
        end
    end

    assign inc_o  = inc;
    assign lost_o = lost_q;

endmodule
